// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: word RAM for ordinary addresses plus an MMIO window at
// 0xFFFF_xxxx holding a cycle counter and a transmit FIFO drained over valid/ready.
module dmem_mmio_responder #(
   parameter int ADDR_WIDTH = 12,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] address_dmem,
   input  logic [31:0] data,
   input  logic        wren,
   output logic [31:0] q_dmem,
   output logic        tx_valid,
   output logic [31:0] tx_data,
   input  logic        tx_ready
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   localparam logic [1:0] OFF_CYCLE     = 2'd0;
   localparam logic [1:0] OFF_TX_DATA   = 2'd1;
   localparam logic [1:0] OFF_TX_STATUS = 2'd2;
   localparam logic [1:0] OFF_TX_DROP   = 2'd3;

   logic [31:0] mem [2**ADDR_WIDTH];
   logic [31:0] fifo_mem [FIFO_DEPTH];

   logic [31:0]      ram_rd_q;
   logic [31:0]      mmio_rd_q, mmio_rd_d;
   logic             rd_is_ram_q, rd_is_ram_d;
   logic [31:0]      cycle_q, cycle_d;
   logic [15:0]      drop_q, drop_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic                  mmio_sel;
   logic [1:0]            mmio_off;
   logic [ADDR_WIDTH-1:0] ram_idx;
   logic                  ram_we;
   logic                  fifo_empty, fifo_full;
   logic                  pop, push_req, push_ok, drop_clr;
   logic [8:0]            count_ext;
   logic [31:0]           status_word;
   logic                  unused_bits;

   assign mmio_sel = (address_dmem[31:16] == 16'hFFFF);
   assign mmio_off = address_dmem[1:0];
   assign ram_idx  = address_dmem[ADDR_WIDTH-1:0];
   assign ram_we   = wren & ~mmio_sel & ~reset;

   assign fifo_empty  = (count_q == '0);
   assign fifo_full   = (count_q == DEPTH_C);
   assign count_ext   = 9'(count_q);
   assign status_word = {16'd0, count_ext[7:0], 6'd0, fifo_full, fifo_empty};

   assign pop      = ~fifo_empty & tx_ready;
   assign push_req = mmio_sel & wren & (mmio_off == OFF_TX_DATA);
   assign push_ok  = push_req & (~fifo_full | pop);
   assign drop_clr = mmio_sel & wren & (mmio_off == OFF_TX_DROP);

   assign tx_valid = ~fifo_empty;
   assign tx_data  = fifo_empty ? 32'd0 : fifo_mem[rd_ptr_q];

   // RAM and MMIO reads are registered separately so the RAM read port stays a plain
   // synchronous read; the select flop picks which one the core sees.
   assign q_dmem = rd_is_ram_q ? ram_rd_q : mmio_rd_q;

   assign unused_bits = ^{address_dmem[15:2], count_ext[8]};

   always_comb begin
      mmio_rd_d   = 32'd0;
      rd_is_ram_d = ~mmio_sel;
      case (mmio_off)
         OFF_CYCLE:     mmio_rd_d = cycle_q;
         OFF_TX_STATUS: mmio_rd_d = status_word;
         OFF_TX_DROP:   mmio_rd_d = {16'd0, drop_q};
         default:       mmio_rd_d = 32'd0;
      endcase

      cycle_d  = cycle_q + 32'd1;
      wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

      count_d = count_q;
      case ({push_ok, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // Clearing wins over a rejected push landing in the same cycle.
      drop_d = drop_q;
      if (drop_clr)
         drop_d = 16'd0;
      else if (push_req && !push_ok && drop_q != 16'hFFFF)
         drop_d = drop_q + 16'd1;
   end

   always_ff @(posedge clock) begin
      if (ram_we)
         mem[ram_idx] <= data;
      ram_rd_q <= mem[ram_idx];
   end

   always_ff @(posedge clock) begin
      if (!reset && push_ok)
         fifo_mem[wr_ptr_q] <= data;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         mmio_rd_q   <= 32'd0;
         rd_is_ram_q <= 1'b0;
         cycle_q     <= 32'd0;
         drop_q      <= 16'd0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         mmio_rd_q   <= mmio_rd_d;
         rd_is_ram_q <= rd_is_ram_d;
         cycle_q     <= cycle_d;
         drop_q      <= drop_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Bench for dmem_mmio_responder: directed scenarios plus random traffic, every cycle
// compared against a queue/array reference model of the memory map.
module tb_dmem_mmio_responder;

   localparam int ADDR_WIDTH = 12;
   localparam int FIFO_DEPTH = 8;

   logic        clock;
   logic        reset;
   logic [31:0] address_dmem;
   logic [31:0] data;
   logic        wren;
   logic [31:0] q_dmem;
   logic        tx_valid;
   logic [31:0] tx_data;
   logic        tx_ready;

   int checkCount = 0;
   int errorCount = 0;

   // Reference model state
   logic [31:0] ramModel [int];
   logic [31:0] fifoModel [$];
   logic [31:0] cycleModel = 0;
   int          dropModel = 0;
   logic [31:0] expQ = 0;
   bit          expQKnown = 0;

   dmem_mmio_responder #(.ADDR_WIDTH(ADDR_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data),
      .wren(wren), .q_dmem(q_dmem), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(tx_ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advances the model by one clock edge using the inputs present before that edge.
   task automatic modelStep(input bit rst, input logic [31:0] addr, input logic [31:0] dat,
                            input bit we, input bit rdy);
      bit mmio, popNow, pushReq, pushOk;
      logic [1:0] off;
      int idx, size;
      if (rst) begin
         fifoModel.delete();
         cycleModel = 0;
         dropModel  = 0;
         expQ       = 0;
         expQKnown  = 1;
         return;
      end
      mmio = (addr[31:16] == 16'hFFFF);
      off  = addr[1:0];
      idx  = int'(addr[ADDR_WIDTH-1:0]);
      size = fifoModel.size();
      expQKnown = 1;
      if (mmio) begin
         case (off)
            2'd0: expQ = cycleModel;
            2'd1: expQ = 0;
            2'd2: expQ = ((size % 256) << 8) + ((size == FIFO_DEPTH) ? 2 : 0) + ((size == 0) ? 1 : 0);
            default: expQ = dropModel;
         endcase
      end else if (ramModel.exists(idx)) begin
         expQ = ramModel[idx];
      end else begin
         expQKnown = 0;
      end
      popNow  = (size > 0) && rdy;
      pushReq = mmio && we && (off == 2'd1);
      pushOk  = pushReq && ((size < FIFO_DEPTH) || popNow);
      if (!mmio && we) ramModel[idx] = dat;
      if (popNow) void'(fifoModel.pop_front());
      if (pushOk) fifoModel.push_back(dat);
      if (mmio && we && off == 2'd3) dropModel = 0;
      else if (pushReq && !pushOk && dropModel < 65535) dropModel++;
      cycleModel = cycleModel + 1;
   endtask

   task automatic applyStimulus(input bit rst, input logic [31:0] addr, input logic [31:0] dat,
                                input bit we, input bit rdy);
      reset        = rst;
      address_dmem = addr;
      data         = dat;
      wren         = we;
      tx_ready     = rdy;
      @(posedge clock);
      modelStep(rst, addr, dat, we, rdy);
      #1;
      if (expQKnown) checkOutput("q_dmem", q_dmem, expQ);
      checkOutput("tx_valid", {31'd0, tx_valid}, (fifoModel.size() > 0) ? 32'd1 : 32'd0);
      checkOutput("tx_data", tx_data, (fifoModel.size() > 0) ? fifoModel[0] : 32'd0);
   endtask

   task automatic idle(input bit rdy);
      applyStimulus(1'b0, 32'h0000_0000, 32'd0, 1'b0, rdy);
   endtask

   initial begin
      int drainExp [$];
      logic [31:0] addr;

      applyStimulus(1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
      checkOutput("reset_q", q_dmem, 32'd0);

      // RAM round trip and read-before-write
      applyStimulus(1'b0, 32'd5, 32'hDEADBEEF, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'd5, 32'd0, 1'b0, 1'b0);
      checkOutput("ram_roundtrip", q_dmem, 32'hDEADBEEF);
      applyStimulus(1'b0, 32'd5, 32'd1, 1'b1, 1'b0);
      checkOutput("ram_rbw_old", q_dmem, 32'hDEADBEEF);
      applyStimulus(1'b0, 32'd5, 32'd0, 1'b0, 1'b0);
      checkOutput("ram_rbw_new", q_dmem, 32'd1);

      // Cycle counter after reset release
      applyStimulus(1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
      for (int i = 1; i <= 9; i++) idle(1'b0);
      applyStimulus(1'b0, 32'hFFFF_0000, 32'd0, 1'b0, 1'b0);
      checkOutput("cycle_10th", q_dmem, 32'd9);

      // Fill past full, check status and drops, then drain
      for (int v = 1; v <= 10; v++) applyStimulus(1'b0, 32'hFFFF_0001, 32'(v), 1'b1, 1'b0);
      applyStimulus(1'b0, 32'hFFFF_0002, 32'd0, 1'b0, 1'b0);
      checkOutput("status_full", q_dmem, 32'h0000_0802);
      applyStimulus(1'b0, 32'hFFFF_0003, 32'd0, 1'b0, 1'b0);
      checkOutput("drop_two", q_dmem, 32'd2);
      for (int k = 1; k <= 8; k++) begin
         checkOutput("drain_order", tx_data, 32'(k));
         idle(1'b1);
      end
      checkOutput("drain_empty", {31'd0, tx_valid}, 32'd0);

      // Push while full and popping in the same cycle
      for (int v = 1; v <= 8; v++) applyStimulus(1'b0, 32'hFFFF_0001, 32'(v), 1'b1, 1'b0);
      applyStimulus(1'b0, 32'hFFFF_0001, 32'd99, 1'b1, 1'b1);
      applyStimulus(1'b0, 32'hFFFF_0002, 32'd0, 1'b0, 1'b0);
      checkOutput("status_pushpop", q_dmem, 32'h0000_0802);
      applyStimulus(1'b0, 32'hFFFF_0003, 32'd0, 1'b0, 1'b0);
      checkOutput("drop_unchanged", q_dmem, 32'd2);
      drainExp = '{2, 3, 4, 5, 6, 7, 8, 99};
      foreach (drainExp[i]) begin
         checkOutput("drain_pushpop", tx_data, 32'(drainExp[i]));
         idle(1'b1);
      end

      // Drop counter saturation and clear (aliased window addresses)
      for (int v = 1; v <= 8; v++) applyStimulus(1'b0, 32'hFFFF_0001, 32'(v), 1'b1, 1'b0);
      for (int i = 0; i < 70000; i++)
         applyStimulus(1'b0, 32'hFFFF_1235, $urandom, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'hFFFF_0003, 32'd0, 1'b0, 1'b0);
      checkOutput("drop_saturated", q_dmem, 32'h0000_FFFF);
      applyStimulus(1'b0, 32'hFFFF_0003, 32'd0, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'hFFFF_0003, 32'd0, 1'b0, 1'b0);
      checkOutput("drop_cleared", q_dmem, 32'd0);

      // Reset mid-transfer keeps RAM, discards FIFO and counters
      applyStimulus(1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 32'd7, 32'hCAFE_F00D, 1'b1, 1'b0);
      for (int v = 1; v <= 3; v++) applyStimulus(1'b0, 32'hFFFF_0001, 32'(v + 40), 1'b1, 1'b0);
      checkOutput("pre_reset_valid", {31'd0, tx_valid}, 32'd1);
      applyStimulus(1'b1, 32'hFFFF_0001, 32'd77, 1'b1, 1'b0);
      checkOutput("post_reset_valid", {31'd0, tx_valid}, 32'd0);
      checkOutput("post_reset_data", tx_data, 32'd0);
      applyStimulus(1'b0, 32'hFFFF_0002, 32'd0, 1'b0, 1'b0);
      checkOutput("post_reset_status", q_dmem, 32'h0000_0001);
      applyStimulus(1'b0, 32'hFFFF_0003, 32'd0, 1'b0, 1'b0);
      checkOutput("post_reset_drop", q_dmem, 32'd0);
      applyStimulus(1'b0, 32'd7, 32'd0, 1'b0, 1'b0);
      checkOutput("post_reset_ram", q_dmem, 32'hCAFE_F00D);

      // Random traffic across RAM (with aliased upper bits) and the MMIO window
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 1) == 0)
            addr = ($urandom & 32'h7FFF_F000) | 32'($urandom_range(0, 15));
         else
            addr = {16'hFFFF, 16'($urandom)};
         applyStimulus($urandom_range(0, 255) == 0, addr, $urandom,
                       $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
